distributor: RTL and testbench

- Registered 1-to-OUT stream demultiplexer. It is the write-side counterpart of the selector: one input word is routed to one output (binary select) or to several outputs (bitmap multicast).
- Each output lane has a one-entry register slot with a valid/ready handshake.
- Sits between a single producer and OUT parallel consumers, e.g. issue to functional-unit queues.

---
 rtl/distributor.sv | 113 +++++++++++
 tb/tb_distributor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/distributor.sv
`default_nettype none
// ============================================================================
// Module   : distributor
// Purpose  : Registered 1-to-OUT stream demultiplexer. One input word is sent
//            to one lane (binary index select) or to several lanes (bitmap
//            multicast select). Each lane has a one-entry output slot with a
//            valid/ready handshake. A word whose target set is empty is
//            accepted and discarded, and drop pulses for one cycle.
// Ports    : clk        - clock, all state changes on the rising edge
//            reset_     - asynchronous active-low reset
//            in_valid   - input word present
//            in_ready   - input word accepted when in_valid && in_ready
//            in_sel     - lane index (binary) or lane bitmap (multicast)
//            in_data    - payload
//            out_valid  - per-lane slot occupied
//            out_ready  - per-lane consumer ready
//            out_data   - lane i is out_data[DATA*i +: DATA]
//            drop       - registered pulse, accepted word had no destination
//            drop_cnt   - saturating drop counter (DISTRIBUTOR_DROP_CNT_EN only)
// Options  : define DISTRIBUTOR_DROP_CNT_EN to add the drop_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module distributor #(
   parameter int DATA      = 32,
   parameter int OUT       = 4,
   parameter bit BIT_MAP   = 1'b0,   // 1: bitmap multicast, 0: binary index
   parameter bit ACT       = 1'b1,   // active level of in_sel bits (bitmap)
   parameter int SEL_WIDTH = BIT_MAP ? OUT : $clog2(OUT)
) (
   input  logic                  clk,
   input  logic                  reset_,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_WIDTH-1:0]  in_sel,
   input  logic [DATA-1:0]       in_data,
   output logic [OUT-1:0]        out_valid,
   input  logic [OUT-1:0]        out_ready,
   output logic [DATA*OUT-1:0]   out_data,
   output logic                  drop
`ifdef DISTRIBUTOR_DROP_CNT_EN
   ,
   output logic [15:0]           drop_cnt
`endif
);

   logic [OUT-1:0] tgt;     // lanes addressed by in_sel
   logic [OUT-1:0] done;    // lanes already written for the current word
   logic [OUT-1:0] need;    // lanes still to be written
   logic [OUT-1:0] free;    // lanes able to take a word this cycle
   logic [OUT-1:0] load;    // lanes written at the coming edge
   logic           accept;

   // Target decode. In binary mode an out-of-range index matches no lane,
   // which makes the word a drop.
   generate
      if (BIT_MAP) begin : g_bitmap
         for (genvar i = 0; i < OUT; i++) begin : g_lane
            assign tgt[i] = (in_sel[i] == ACT);
         end
      end else begin : g_binary
         for (genvar i = 0; i < OUT; i++) begin : g_lane
            assign tgt[i] = (in_sel == SEL_WIDTH'(i));
         end
      end
   endgenerate

   // A slot that is draining this cycle counts as free, giving one word per
   // cycle per lane when the consumer keeps out_ready high.
   assign free     = ~out_valid | out_ready;
   assign need     = tgt & ~done;
   assign load     = in_valid ? (need & free) : '0;
   assign in_ready = in_valid ? ((need & ~free) == '0) : 1'b1;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         out_valid <= '0;
         out_data  <= '0;
         drop      <= 1'b0;
         done      <= '0;
      end else begin
         for (int i = 0; i < OUT; i++) begin
            if (load[i]) begin
               out_valid[i]               <= 1'b1;
               out_data[DATA*i +: DATA]   <= in_data;
            end else if (out_ready[i]) begin
               // Data is left in place; only the valid flag clears.
               out_valid[i] <= 1'b0;
            end
         end
         drop <= accept && (tgt == '0);
         // Partial multicast progress is remembered until the word is
         // accepted, so already-written lanes are not written twice.
         if (accept) begin
            done <= '0;
         end else if (in_valid) begin
            done <= done | load;
         end
      end
   end

`ifdef DISTRIBUTOR_DROP_CNT_EN
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         drop_cnt <= 16'h0000;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'h0001;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_distributor.sv
`default_nettype none
// ============================================================================
// Module   : tb_distributor
// Purpose  : Directed self-checking bench for distributor. Four instances:
//            binary OUT=4, bitmap OUT=4 active-high, binary OUT=3, and
//            bitmap OUT=4 active-low, all with 8-bit data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_distributor;

   logic clk;
   logic reset_;

   int n_asserts = 0;
   int n_fail    = 0;

   // binary, OUT=4
   logic        b_valid, b_ready, b_drop;
   logic [1:0]  b_sel;
   logic [7:0]  b_data;
   logic [3:0]  b_ovalid, b_oready;
   logic [31:0] b_odata;
   // bitmap, OUT=4, active high
   logic        m_valid, m_ready, m_drop;
   logic [3:0]  m_sel;
   logic [7:0]  m_data;
   logic [3:0]  m_ovalid, m_oready;
   logic [31:0] m_odata;
   // binary, OUT=3
   logic        t_valid, t_ready, t_drop;
   logic [1:0]  t_sel;
   logic [7:0]  t_data;
   logic [2:0]  t_ovalid, t_oready;
   logic [23:0] t_odata;
   // bitmap, OUT=4, active low
   logic        l_valid, l_ready, l_drop;
   logic [3:0]  l_sel;
   logic [7:0]  l_data;
   logic [3:0]  l_ovalid, l_oready;
   logic [31:0] l_odata;
`ifdef DISTRIBUTOR_DROP_CNT_EN
   logic [15:0] b_cnt, m_cnt, t_cnt, l_cnt;
`endif

   distributor #(.DATA(8), .OUT(4), .BIT_MAP(1'b0)) u_bin (
      .clk(clk), .reset_(reset_), .in_valid(b_valid), .in_ready(b_ready),
      .in_sel(b_sel), .in_data(b_data), .out_valid(b_ovalid),
      .out_ready(b_oready), .out_data(b_odata), .drop(b_drop)
`ifdef DISTRIBUTOR_DROP_CNT_EN
      , .drop_cnt(b_cnt)
`endif
   );

   distributor #(.DATA(8), .OUT(4), .BIT_MAP(1'b1), .ACT(1'b1)) u_map (
      .clk(clk), .reset_(reset_), .in_valid(m_valid), .in_ready(m_ready),
      .in_sel(m_sel), .in_data(m_data), .out_valid(m_ovalid),
      .out_ready(m_oready), .out_data(m_odata), .drop(m_drop)
`ifdef DISTRIBUTOR_DROP_CNT_EN
      , .drop_cnt(m_cnt)
`endif
   );

   distributor #(.DATA(8), .OUT(3), .BIT_MAP(1'b0)) u_b3 (
      .clk(clk), .reset_(reset_), .in_valid(t_valid), .in_ready(t_ready),
      .in_sel(t_sel), .in_data(t_data), .out_valid(t_ovalid),
      .out_ready(t_oready), .out_data(t_odata), .drop(t_drop)
`ifdef DISTRIBUTOR_DROP_CNT_EN
      , .drop_cnt(t_cnt)
`endif
   );

   distributor #(.DATA(8), .OUT(4), .BIT_MAP(1'b1), .ACT(1'b0)) u_low (
      .clk(clk), .reset_(reset_), .in_valid(l_valid), .in_ready(l_ready),
      .in_sel(l_sel), .in_data(l_data), .out_valid(l_ovalid),
      .out_ready(l_oready), .out_data(l_odata), .drop(l_drop)
`ifdef DISTRIBUTOR_DROP_CNT_EN
      , .drop_cnt(l_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_   = 1'b0;
      b_valid  = 0; b_sel = 0; b_data = 0; b_oready = 0;
      m_valid  = 0; m_sel = 0; m_data = 0; m_oready = 0;
      t_valid  = 0; t_sel = 0; t_data = 0; t_oready = 0;
      l_valid  = 0; l_sel = 0; l_data = 0; l_oready = 0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_b_ovalid", b_ovalid, 4'b0000);
      chk("rst_b_odata",  b_odata,  32'h0);
      chk("rst_b_drop",   b_drop,   1'b0);
      chk("rst_b_ready",  b_ready,  1'b1);
      chk("rst_m_ovalid", m_ovalid, 4'b0000);
      chk("rst_t_ovalid", t_ovalid, 3'b000);
`ifdef DISTRIBUTOR_DROP_CNT_EN
      chk("rst_m_cnt",    m_cnt,    16'h0);
`endif
      reset_ = 1'b1;
      tick();

      // ---------------- binary full throughput ----------------
      b_oready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         b_valid = 1'b1;
         b_sel   = 2'(k);
         b_data  = 8'(k + 1);
         #1;
         chk("thru_ready", b_ready, 1'b1);
         tick();
         chk("thru_ovalid", b_ovalid, 32'(1 << k));
         chk("thru_data",   b_odata[8*k +: 8], 32'(k + 1));
      end
      b_valid = 1'b0;

      // ---------------- binary back-pressure on lane 2 ----------------
      b_oready = 4'b1011;
      b_valid  = 1'b1; b_sel = 2'd2; b_data = 8'h0A;
      #1;
      chk("bp_ready_a", b_ready, 1'b1);
      tick();
      chk("bp_ovalid_a", b_ovalid[2], 1'b1);
      chk("bp_data_a",   b_odata[23:16], 8'h0A);
      b_data = 8'h0B;
      #1;
      chk("bp_ready_b_blocked", b_ready, 1'b0);
      tick();
      chk("bp_hold_valid", b_ovalid[2], 1'b1);
      chk("bp_hold_data",  b_odata[23:16], 8'h0A);
      chk("bp_still_blocked", b_ready, 1'b0);
      b_oready = 4'b1111;
      #1;
      chk("bp_ready_b_open", b_ready, 1'b1);
      tick();
      b_valid = 1'b0;
      chk("bp_ovalid_b", b_ovalid[2], 1'b1);
      chk("bp_data_b",   b_odata[23:16], 8'h0B);

      // ---------------- bitmap partial multicast ----------------
      m_oready = 4'b1110;
      m_valid = 1'b1; m_sel = 4'b0001; m_data = 8'h11;   // fill lane 0
      tick();
      chk("mc_pre_ovalid", m_ovalid, 4'b0001);
      m_sel = 4'b1011; m_data = 8'h55;
      #1;
      chk("mc_ready0", m_ready, 1'b0);
      tick();
      chk("mc_ovalid1", m_ovalid, 4'b1011);
      chk("mc_lane1",   m_odata[15:8],  8'h55);
      chk("mc_lane3",   m_odata[31:24], 8'h55);
      chk("mc_lane0",   m_odata[7:0],   8'h11);
      chk("mc_ready1",  m_ready, 1'b0);
      tick();
      chk("mc_ovalid2", m_ovalid, 4'b0001);
      chk("mc_ready2",  m_ready, 1'b0);
      m_oready = 4'b1111;
      #1;
      chk("mc_ready3", m_ready, 1'b1);
      tick();
      m_valid = 1'b0;
      chk("mc_ovalid3", m_ovalid, 4'b0001);
      chk("mc_lane0_new", m_odata[7:0], 8'h55);
      tick();
      chk("mc_drained", m_ovalid, 4'b0000);

      // ---------------- drop, bitmap empty ----------------
      m_valid = 1'b1; m_sel = 4'b0000; m_data = 8'hEE;
      #1;
      chk("drop_m_ready", m_ready, 1'b1);
      tick();
      m_valid = 1'b0;
      chk("drop_m_pulse",  m_drop, 1'b1);
      chk("drop_m_ovalid", m_ovalid, 4'b0000);
      tick();
      chk("drop_m_end", m_drop, 1'b0);
`ifdef DISTRIBUTOR_DROP_CNT_EN
      chk("drop_m_cnt", m_cnt, 16'd1);
`endif

      // ---------------- binary OUT=3, out-of-range index ----------------
      t_oready = 3'b111;
      t_valid = 1'b1; t_sel = 2'd2; t_data = 8'h33;
      #1;
      chk("b3_ready_ok", t_ready, 1'b1);
      tick();
      t_sel = 2'd3;
      #1;
      chk("b3_ready_drop", t_ready, 1'b1);
      chk("b3_ovalid_ok",  t_ovalid, 3'b100);
      chk("b3_lane2",      t_odata[23:16], 8'h33);
      chk("b3_nodrop",     t_drop, 1'b0);
      tick();
      t_valid = 1'b0;
      chk("b3_drop",        t_drop, 1'b1);
      chk("b3_ovalid_drop", t_ovalid, 3'b000);
      tick();
      chk("b3_drop_end", t_drop, 1'b0);
`ifdef DISTRIBUTOR_DROP_CNT_EN
      chk("b3_cnt", t_cnt, 16'd1);
`endif

      // ---------------- reset mid-multicast ----------------
      m_oready = 4'b1110;
      m_valid = 1'b1; m_sel = 4'b0001; m_data = 8'h22;
      tick();
      m_sel = 4'b1011; m_data = 8'h66;
      tick();
      chk("rm_ovalid_pre", m_ovalid, 4'b1011);
      #2;
      reset_ = 1'b0;
      #1;
      chk("rm_async_ovalid", m_ovalid, 4'b0000);
      chk("rm_async_drop",   m_drop, 1'b0);
      chk("rm_async_ready",  m_ready, 1'b1);
      tick();
      reset_ = 1'b1;
      #1;
      chk("rm_ready_rel", m_ready, 1'b1);
      tick();
      m_valid = 1'b0;
      chk("rm_ovalid_post", m_ovalid, 4'b1011);
      chk("rm_lane0", m_odata[7:0],   8'h66);
      chk("rm_lane1", m_odata[15:8],  8'h66);
      chk("rm_lane3", m_odata[31:24], 8'h66);

      // ---------------- bitmap active-low ----------------
      l_oready = 4'b1111;
      l_valid = 1'b1; l_sel = 4'b1010; l_data = 8'h77;
      #1;
      chk("low_ready", l_ready, 1'b1);
      tick();
      l_valid = 1'b0;
      chk("low_ovalid", l_ovalid, 4'b0101);
      chk("low_lane0",  l_odata[7:0],   8'h77);
      chk("low_lane2",  l_odata[23:16], 8'h77);
      chk("low_lane1",  l_odata[15:8],  8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
